// File: rtl/read_ptr_empty_logic_pkg.sv
// Shared pointer helpers for the async FIFO pointer/flag blocks (read and write sides).
package read_ptr_empty_logic_pkg;

  // Flag bundle computed ahead of the register stage.
  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic underflow;
  } rd_flags_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; unused upper bits are zero and stay zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/read_ptr_empty_logic_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  // NOTE: registered state uses non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/read_ptr_empty_logic.sv
// Read-domain pointer, empty/almost-empty flags, occupancy and underflow for a Gray-pointer async FIFO.
module read_ptr_empty_logic
  import read_ptr_empty_logic_pkg::*;
#(
  parameter int          address      = 2,
  parameter int unsigned ALMOST_EMPTY = 1
) (
  input  logic             rclk,
  input  logic             rreset,
  input  logic             ren,
  input  logic [address:0] write_ptr_gray,
  output logic [address:0] read_ptr,
  output logic [address:0] read_ptr_gray,
  output logic             empty,
  output logic             almost_empty,
  output logic [address:0] rd_level,
  output logic             underflow
);

  localparam int W = address + 1;

  logic [W-1:0] wq2;
  logic [W-1:0] read_ptr_next;
  logic [W-1:0] rgray_next;
  logic [W-1:0] level_next;
  logic         rd_accept;
  rd_flags_t    flags_next;

  // write_ptr_gray is sampled nowhere else: only the synchronized copy feeds the compare.
  sync_2ff #(.WIDTH(W)) u_wsync (
    .clk   (rclk),
    .reset (rreset),
    .d     (write_ptr_gray),
    .q     (wq2)
  );

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    rd_accept     = ren & ~empty;
    read_ptr_next = read_ptr + W'(rd_accept);
    rgray_next    = W'(bin2gray(32'(read_ptr_next)));
    level_next    = W'(gray2bin(32'(wq2))) - read_ptr_next;
    flags_next.empty        = (rgray_next == wq2);
    flags_next.almost_empty = (32'(level_next) <= ALMOST_EMPTY);
    flags_next.underflow    = ren & empty;
  end

  // Flags look at the post-accept pointer, so draining the last word raises empty on that same edge.
  always_ff @(posedge rclk) begin
    if (rreset) begin
      read_ptr      <= '0;
      read_ptr_gray <= '0;
      empty         <= 1'b1;
      almost_empty  <= 1'b1;
      rd_level      <= '0;
      underflow     <= 1'b0;
    end else begin
      read_ptr      <= read_ptr_next;
      read_ptr_gray <= rgray_next;
      empty         <= flags_next.empty;
      almost_empty  <= flags_next.almost_empty;
      rd_level      <= level_next;
      underflow     <= flags_next.underflow;
    end
  end

endmodule

// File: tb/tb_read_ptr_empty_logic.sv
// Self-checking bench: directed scenarios plus a randomized stretch against a count-based model.
module tb_read_ptr_empty_logic;

  logic       rclk = 1'b0;
  logic       rreset;
  logic       ren;
  logic [2:0] write_ptr_gray;
  logic [2:0] read_ptr;
  logic [2:0] read_ptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [2:0] rd_level;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  // Model works in unbounded item counts; pointers are those counts mod 8.
  int wcnt    = 0;
  int m_rcnt  = 0;
  int m_hist[$];
  int m_level = 0;
  bit m_empty = 1'b1;
  bit m_under = 1'b0;

  read_ptr_empty_logic #(.address(2), .ALMOST_EMPTY(1)) dut (
    .rclk           (rclk),
    .rreset         (rreset),
    .ren            (ren),
    .write_ptr_gray (write_ptr_gray),
    .read_ptr       (read_ptr),
    .read_ptr_gray  (read_ptr_gray),
    .empty          (empty),
    .almost_empty   (almost_empty),
    .rd_level       (rd_level),
    .underflow      (underflow)
  );

  always #5 rclk = ~rclk;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // The write count reaches the compare two edges after it is presented.
  task automatic model_edge(input bit r, input bit rst);
    int seen;
    if (rst) begin
      m_rcnt  = 0;
      m_hist  = '{0, 0};
      m_level = 0;
      m_empty = 1'b1;
      m_under = 1'b0;
    end else begin
      seen    = m_hist[0];
      m_under = r & m_empty;
      if (r && !m_empty) m_rcnt++;
      m_level = seen - m_rcnt;
      m_empty = (m_level == 0);
      void'(m_hist.pop_front());
      m_hist.push_back(wcnt);
    end
  endtask

  task automatic step(input bit r, input bit rst);
    ren            = r;
    rreset         = rst;
    write_ptr_gray = 3'(gray(wcnt % 8));
    @(posedge rclk);
    model_edge(r, rst);
    #1;
    check("read_ptr",      int'(read_ptr),      m_rcnt % 8);
    check("read_ptr_gray", int'(read_ptr_gray), gray(m_rcnt % 8));
    check("empty",         int'(empty),         int'(m_empty));
    check("almost_empty",  int'(almost_empty),  int'(m_level <= 1));
    check("rd_level",      int'(rd_level),      m_level);
    check("underflow",     int'(underflow),     int'(m_under));
  endtask

  initial begin
    m_hist = '{0, 0};
    ren = 1'b0;
    rreset = 1'b1;
    write_ptr_gray = 3'b000;

    // Reset held for two edges with a non-zero remote pointer (gray 010 = count 3)
    wcnt = 3;
    step(0, 1);
    step(0, 1);
    check("t1_reset_ptr", int'(read_ptr), 0);
    check("t1_reset_empty", int'(empty), 1);
    check("t1_reset_level", int'(rd_level), 0);
    step(0, 0);
    step(0, 0);
    check("t1_empty_before_3rd", int'(empty), 1);
    step(0, 0);
    check("t1_empty_3rd", int'(empty), 0);
    check("t1_level_3rd", int'(rd_level), 3);
    check("t1_almost_3rd", int'(almost_empty), 0);

    // Underflow on an empty FIFO
    wcnt = 0;
    step(0, 1);
    step(1, 0);
    check("t2_underflow_1", int'(underflow), 1);
    step(1, 0);
    check("t2_underflow_2", int'(underflow), 1);
    check("t2_ptr_stays", int'(read_ptr), 0);
    step(0, 0);
    check("t2_underflow_off", int'(underflow), 0);

    // Drain three words, fourth read underflows
    wcnt = 3;
    repeat (3) step(0, 0);
    step(1, 0);
    check("t3_gray_1", int'(read_ptr_gray), 3'b001);
    step(1, 0);
    check("t3_almost_lvl1", int'(almost_empty), 1);
    step(1, 0);
    check("t3_empty_3rd", int'(empty), 1);
    check("t3_gray_3", int'(read_ptr_gray), 3'b010);
    step(1, 0);
    check("t3_ptr_4th", int'(read_ptr), 3);
    check("t3_under_4th", int'(underflow), 1);

    // Randomized continuous traffic across several pointer laps
    for (int i = 0; i < 120; i++) begin
      if ((wcnt - m_rcnt) < 4 && ($urandom_range(3, 0) != 0)) wcnt++;
      step(($urandom_range(4, 0) != 0), 0);
      check("t4_level_le4", int'(rd_level <= 3'd4), 1);
    end
    check("t4_two_laps", int'(m_rcnt >= 16), 1);

    // Last read on the same edge the remote pointer moves 010 -> 110
    wcnt = 0;
    step(0, 1);
    wcnt = 3;
    repeat (3) step(0, 0);
    step(1, 0);
    step(1, 0);
    wcnt = 4;
    step(1, 0);
    check("t5_empty_e0", int'(empty), 1);
    step(0, 0);
    check("t5_empty_e1", int'(empty), 1);
    step(0, 0);
    check("t5_empty_e2", int'(empty), 0);
    check("t5_level_e2", int'(rd_level), 1);

    // Mid-operation reset at read_ptr=5 with data pending; ren during reset ignored
    step(1, 0);
    wcnt = 7;
    repeat (3) step(0, 0);
    step(1, 0);
    check("t6_ptr5", int'(read_ptr), 5);
    check("t6_nonempty", int'(empty), 0);
    wcnt = 0;
    step(1, 1);
    check("t6_rst_ptr", int'(read_ptr), 0);
    check("t6_rst_gray", int'(read_ptr_gray), 0);
    check("t6_rst_empty", int'(empty), 1);
    check("t6_rst_almost", int'(almost_empty), 1);
    check("t6_rst_level", int'(rd_level), 0);
    check("t6_rst_under", int'(underflow), 0);
    step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
